// File: rtl/ruhman_led_multi.sv
// ruhman_led_multi: N-channel LED sequencer (off / on / blink / burst) on the FPro MMIO slot bus.
// Define RUHMAN_LED_BREATHE_EN to turn mode 11 into a 16-step PWM breathe instead of burst.
module ruhman_led_multi #(
    parameter int unsigned N          = 16,
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned HP_W       = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [N-1:0] dout
);
    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeOn    = 2'b01,
        ModeBlink = 2'b10,
        ModeBurst = 2'b11
    } mode_e;

    localparam int unsigned   PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PrescLast  = PW'(CLK_PER_MS - 1);
    localparam logic [4:0]    AddrSync   = 5'd16;
    localparam logic [4:0]    AddrStatus = 5'd17;

    logic [PW-1:0]   presc_q, presc_d;
    logic            ms_tick;
    logic            bus_wr;
    logic [HP_W-1:0] ch_hp   [N];
    logic [1:0]      ch_mode [N];
    logic [3:0]      ch_bc   [N];
    logic [N-1:0]    done_vec;
    logic            unused_bits;

    assign bus_wr      = cs && write;
    assign ms_tick     = (presc_q == PrescLast);
    assign presc_d     = ms_tick ? '0 : presc_q + PW'(1);
    // Reads have no side effects and several write-data bits are don't-care.
    assign unused_bits = read ^ (^wr_data);

    always_ff @(posedge clk) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= presc_d;
    end

`ifdef RUHMAN_LED_BREATHE_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk) begin
        if (!reset_n) pwm_q <= '0;
        else          pwm_q <= pwm_q + 4'd1;
    end
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [HP_W-1:0] hp_q, hp_d, cnt_q, cnt_d, hp_eff;
        mode_e           mode_q, mode_d;
        logic [3:0]      bc_q, bc_d;
        logic [4:0]      rem_q, rem_d;
        logic            led_q, led_d, done_q, done_d;
        logic            cfg_wr, sync_wr, active, step;

        assign cfg_wr  = bus_wr && (addr == 5'(i));
        assign sync_wr = bus_wr && (addr == AddrSync) && wr_data[i];
        assign active  = (mode_q == ModeBlink) || (mode_q == ModeBurst);
        assign hp_eff  = (hp_q == '0) ? HP_W'(1) : hp_q;
        assign step    = (cnt_q == hp_eff - HP_W'(1));

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                hp_q   <= '0;
                mode_q <= ModeOff;
                bc_q   <= '0;
                cnt_q  <= '0;
                rem_q  <= '0;
                led_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                hp_q   <= hp_d;
                mode_q <= mode_d;
                bc_q   <= bc_d;
                cnt_q  <= cnt_d;
                rem_q  <= rem_d;
                led_q  <= led_d;
                done_q <= done_d;
            end
        end

        always_comb begin
            hp_d   = hp_q;
            mode_d = mode_q;
            bc_d   = bc_q;
            cnt_d  = cnt_q;
            rem_d  = rem_q;
            led_d  = led_q;
            done_d = done_q;
            if (cfg_wr) begin
                hp_d   = wr_data[HP_W-1:0];
                mode_d = mode_e'(wr_data[17:16]);
                bc_d   = wr_data[23:20];
            end
            // A restart pre-empts any ms_tick landing on the same cycle for this channel.
            if (cfg_wr || (sync_wr && active)) begin
                cnt_d  = '0;
                done_d = 1'b0;
                led_d  = (mode_d != ModeOff);
                rem_d  = (bc_d == 4'd0) ? 5'd16 : {1'b0, bc_d};
`ifdef RUHMAN_LED_BREATHE_EN
                if (mode_d == ModeBurst) rem_d = '0;
`endif
            end else if (ms_tick && active && !done_q) begin
                if (step) begin
                    cnt_d = '0;
                    led_d = !led_q;
`ifdef RUHMAN_LED_BREATHE_EN
                    // rem[3:0] is the duty, rem[4] the ramp direction (1 = falling).
                    if (mode_q == ModeBurst) begin
                        if (!rem_q[4]) rem_d = (rem_q[3:0] == 4'd15) ? 5'b1_1110 : rem_q + 5'd1;
                        else           rem_d = (rem_q[3:0] == 4'd0) ? 5'b0_0001 : rem_q - 5'd1;
                    end
`else
                    if ((mode_q == ModeBurst) && led_q) begin
                        rem_d  = rem_q - 5'd1;
                        done_d = (rem_q == 5'd1);
                    end
`endif
                end else begin
                    cnt_d = cnt_q + HP_W'(1);
                end
            end
`ifdef RUHMAN_LED_BREATHE_EN
            if (mode_d == ModeBurst) led_d = (pwm_q < rem_d[3:0]);
`endif
        end

        assign dout[i]     = led_q;
        assign done_vec[i] = done_q;
        assign ch_hp[i]    = hp_q;
        assign ch_mode[i]  = mode_q;
        assign ch_bc[i]    = bc_q;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (addr == 5'(i)) rd_data = {8'h00, ch_bc[i], 2'b00, ch_mode[i], 16'(ch_hp[i])};
        end
        if (addr == AddrStatus) begin
            rd_data[N-1:0]  = dout;
            rd_data[16 +: N] = done_vec;
        end
    end
endmodule

// File: tb/tb_ruhman_led_multi.sv
// Scoreboard bench for ruhman_led_multi: a closed-form tick-count model predicts dout and
// rd_data every cycle; a negedge monitor pops and compares.
module tb_ruhman_led_multi;
    localparam int unsigned N          = 8;
    localparam int unsigned CLK_PER_MS = 4;
    localparam int unsigned HP_W       = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [N-1:0] dout;

    always #5 clk = ~clk;

    ruhman_led_multi #(
        .N          (N),
        .CLK_PER_MS (CLK_PER_MS),
        .HP_W       (HP_W)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    typedef struct packed {
        logic [N-1:0] dout;
        logic [31:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: each active channel is described only by the tick index of its last restart.
    int m_mode [N];
    int m_hp   [N];
    int m_bc   [N];
    int m_base [N];
    int edges = 0;
    int ticks = 0;

    function automatic int hpe_of(int i);
        return (m_hp[i] == 0) ? 1 : m_hp[i];
    endfunction

    // Ticks from restart until the last falling edge of the burst.
    function automatic int burst_len(int i);
        int n;
        n = (m_bc[i] == 0) ? 16 : m_bc[i];
        return hpe_of(i) * (2 * n - 1);
    endfunction

    function automatic logic m_done(int i);
        return (m_mode[i] == 3) && ((ticks - m_base[i]) >= burst_len(i));
    endfunction

    function automatic logic m_led(int i);
        int k;
        k = ticks - m_base[i];
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((k / hpe_of(i)) % 2) == 0;
            default: return (k >= burst_len(i)) ? 1'b0 : (((k / hpe_of(i)) % 2) == 0);
        endcase
    endfunction

    function automatic logic [N-1:0] m_dout();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_led(i);
        return v;
    endfunction

    function automatic logic [31:0] m_rd(int a);
        logic [31:0] v;
        v = '0;
        if (a < N) begin
            v = {8'h00, 4'(m_bc[a]), 2'b00, 2'(m_mode[a]), 16'(m_hp[a])};
        end else if (a == 17) begin
            for (int i = 0; i < N; i++) begin
                v[i]      = m_led(i);
                v[16 + i] = m_done(i);
            end
        end
        return v;
    endfunction

    // Apply the edge that just happened using the inputs the bench had been driving.
    task automatic model_step();
        int a;
        a = int'(addr);
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_mode[i] = 0;
                m_hp[i]   = 0;
                m_bc[i]   = 0;
                m_base[i] = 0;
            end
            edges = 0;
            ticks = 0;
        end else begin
            if ((edges % CLK_PER_MS) == CLK_PER_MS - 1) ticks++;
            edges++;
            if (cs && write) begin
                if (a < N) begin
                    m_mode[a] = int'(wr_data[17:16]);
                    m_hp[a]   = int'(wr_data[HP_W-1:0]);
                    m_bc[a]   = int'(wr_data[23:20]);
                    m_base[a] = ticks;
                end else if (a == 16) begin
                    for (int i = 0; i < N; i++)
                        if (wr_data[i] && (m_mode[i] >= 2)) m_base[i] = ticks;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic w, input int a,
                         input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        reset_n = r;
        cs      = c;
        write   = w;
        read    = c && !w;
        addr    = 5'(a);
        wr_data = d;
        e.dout  = m_dout();
        e.rd    = m_rd(a);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input int a);
        for (int j = 0; j < n; j++) cycle(1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b1, a, d);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (dout !== mon_e.dout) begin
                errors++;
                $display("FAIL dout t=%0t got %h expected %h", $time, dout, mon_e.dout);
            end
            checks++;
            if (rd_data !== mon_e.rd) begin
                errors++;
                $display("FAIL rd_data addr=%0d t=%0t got %h expected %h",
                         addr, $time, rd_data, mon_e.rd);
            end
        end
    end

    initial begin
        logic [31:0] d;
        int          r;
        int          a;

        reset_n = 1'b0;
        cs      = 1'b1;
        write   = 1'b1;
        read    = 1'b0;
        addr    = 5'd0;
        wr_data = 32'h0002_0003;

        // Write held during reset must be ignored.
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 0, 32'h0002_0003);
        idle(5, 0);

        // Blink, hp=3.
        wr(2, 32'h0002_0003);
        idle(30, 2);

        // Burst of 3, hp=2.
        wr(5, 32'h0033_0002);
        idle(60, 17);

        // hp=0 blink and burst_cnt=0 burst.
        wr(3, 32'h0002_0000);
        wr(4, 32'h0003_0000);
        idle(140, 17);

        // Two offset blinkers, then SYNC both.
        wr(0, 32'h0002_0002);
        idle(4, 17);
        wr(1, 32'h0002_0002);
        idle(10, 17);
        wr(16, 32'h0000_0003);
        idle(30, 17);

        // SYNC on a steady-on channel has no effect.
        wr(6, 32'h0001_0000);
        wr(16, 32'h0000_0040);
        idle(3, 6);

        // Config write landing on an ms_tick edge.
        for (int j = 0; j < CLK_PER_MS && (edges % CLK_PER_MS) != CLK_PER_MS - 1; j++)
            idle(1, 17);
        wr(0, 32'h0002_0002);
        idle(20, 17);

        // Out-of-range channel and unmapped addresses.
        wr(9, 32'h0002_0001);
        idle(2, 9);
        wr(20, 32'hFFFF_FFFF);
        idle(2, 20);
        idle(2, 16);

        for (int j = 0; j < 2000; j++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                repeat (2) cycle(1'b0, 1'b1, 1'b1, $urandom_range(0, N - 1), $urandom);
            end else if (r < 14) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = $urandom_range(0, N - 1);
                else if (r < 8) a = 16;
                else            a = $urandom_range(0, 31);
                d = $urandom;
                d[7:0] = 8'($urandom_range(0, 3));
                wr(a, d);
            end else begin
                idle(1, $urandom_range(0, 31));
            end
        end

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
